tensor_core_scheduler: RTL and testbench
========================================

TENSOR_CORE_SCHEDULER -- requirements
Module: tensor_core_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, giving the number of requester ports (legal range 2..4).
REQ-002 The block SHALL have parameter TIMEOUT, default 24, giving the maximum WAIT cycles before a job is aborted.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clock_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port req_valid, input, NUM_REQ bits: requester i has a job pending.
REQ-007 Port req_ready, output, NUM_REQ bits: job from requester i accepted this cycle.
REQ-008 Port req_a / req_b, input, NUM_REQ*128 bits each: packed 4x4 int8 operand matrices, slice i per requester.
REQ-009 Port resp_valid, output, NUM_REQ bits: result for requester i available.
REQ-010 Port resp_ready, input, NUM_REQ bits: requester i consumes its result.
REQ-011 Port resp_data, output, 128 bits: result matrix, shared by all requesters.
REQ-012 Port resp_error, output, 1 bit: the current response is a timeout abort.
REQ-013 Port tc_write_enable, output, 1 bit: start pulse to the tensor core.
REQ-014 Port tc_input1 / tc_input2, output, 128 bits each: registered operands driven to the tensor core.
REQ-015 Port tc_output, input, 128 bits: tensor core result.
REQ-016 Port tc_done, input, 1 bit: tensor core done flag.
REQ-017 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-019 IDLE: when any req_valid bit is high, the block SHALL grant round-robin starting at (last_grant+1) mod NUM_REQ, pulse req_ready[grant] for exactly one cycle, latch the operands into tc_input1/tc_input2, and go to ISSUE.
REQ-020 ISSUE: tc_write_enable SHALL be high for exactly this one cycle; the next state is WAIT.
REQ-021 WAIT: tc_done SHALL be ignored in the first WAIT cycle, because done is stale from the previous job.
REQ-022 WAIT: from the second WAIT cycle on, tc_done=1 SHALL latch tc_output into resp_data, clear resp_error, and go to RESP.
REQ-023 WAIT: a wait counter SHALL count WAIT cycles; if it reaches TIMEOUT without done, resp_data SHALL be set to 0, resp_error set to 1, and the FSM SHALL go to RESP.
REQ-024 RESP: resp_valid[grant] SHALL be held high until resp_ready[grant]=1, then the FSM SHALL return to IDLE and update last_grant to grant.
REQ-025 resp_ready on non-granted ports SHALL be ignored.
REQ-026 Latency SHALL be fixed: acceptance at cycle 0, tc_write_enable at cycle 1, result no earlier than cycle 3; with the nominal 17-cycle core, resp_valid rises at cycle 19.
REQ-027 At most one job SHALL be outstanding; req_ready SHALL be 0 in every state except IDLE.
REQ-028 Operands SHALL be held stable on tc_input1/tc_input2 from ISSUE until RESP exits.
REQ-029 A requester that drops req_valid before it is granted SHALL NOT be granted.
REQ-030 The round-robin pointer SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-031 Asserting reset_n low SHALL asynchronously force the FSM to IDLE and last_grant to NUM_REQ-1, so requester 0 wins first.
REQ-032 Reset SHALL clear all outputs to 0, including tc_input1, tc_input2, resp_data, wait counter and busy.
REQ-033 Reset mid-job SHALL abandon the job: no response is issued and the tensor core's internal state is don't-care.

Structure
REQ-034 The state enum, the MAT_W=128 and ELEM_W=8 constants, and the TIMEOUT default SHALL live in shared package tensor_core_pkg.
REQ-035 The round-robin arbiter SHALL be one sub-module, rr_arbiter (inputs: request vector, last_grant; output: one-hot grant).
REQ-036 The block SHALL NOT instantiate the tensor core itself; it connects at the next level up.

Verification
REQ-037 Single job: req_valid[0]=1 with A=identity, B=all 2 -> one tc_write_enable pulse, resp_valid[0] with resp_data=all 0x02 and resp_error=0.
REQ-038 Contention: req_valid=2'b11 held for three jobs -> grants in order 0,1,0, and req_ready is never high outside IDLE.
REQ-039 Stale done: tc_done=1 throughout ISSUE and the first WAIT cycle -> not accepted; the result is taken from the second WAIT cycle onward.
REQ-040 Timeout: tc_done tied 0 -> after 24 WAIT cycles, resp_valid=1, resp_error=1, resp_data=0.
REQ-041 Backpressure: resp_ready held 0 for 10 cycles -> resp_valid and resp_data stay stable, and no new grant occurs.
REQ-042 Reset mid-WAIT: reset_n pulsed low -> busy=0 and all outputs 0 immediately; the next request is granted to port 0.

Source files
------------

// File: rtl/tensor_core_pkg.sv
// rtl/tensor_core_pkg.sv - shared types and constants for the tensor core scheduler
package tensor_core_pkg;

    localparam int MAT_W           = 128;
    localparam int ELEM_W          = 8;
    localparam int TIMEOUT_DEFAULT = 24;

    // An aborted job returns a matrix whose every element is zero.
    localparam logic [MAT_W-1:0] ABORT_DATA = {(MAT_W/ELEM_W){{ELEM_W{1'b0}}}};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of one requester, searching from last_grant+1
// Ports:
//   request    - pending request per port
//   last_grant - index of the most recently served port
//   grant      - one-hot winner, all zero when nothing is requested
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    // Walk the ports in priority order (last_grant+1, +2, ... wrapping) and
    // keep the first one that is requesting.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && request[i] &&
                    (i == (int'(last_grant) + off) % NUM_REQ)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tensor_core_scheduler.sv
// rtl/tensor_core_scheduler.sv - shares one tensor core among NUM_REQ requesters, one job at a time
// Ports:
//   clock_in, reset_n            - clock, asynchronous active-low reset
//   req_valid/req_ready          - job handshake per requester; req_a/req_b packed operands
//   resp_valid/resp_ready        - result handshake per requester; resp_data/resp_error shared
//   tc_write_enable, tc_input1/2 - start pulse and held operands to the tensor core
//   tc_output, tc_done           - tensor core result and done flag
//   busy                         - a job is in flight
module tensor_core_scheduler
    import tensor_core_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                     clock_in,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*MAT_W-1:0] req_a,
    input  logic [NUM_REQ*MAT_W-1:0] req_b,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [MAT_W-1:0]         resp_data,
    output logic                     resp_error,
    output logic                     tc_write_enable,
    output logic [MAT_W-1:0]         tc_input1,
    output logic [MAT_W-1:0]         tc_input2,
    input  logic [MAT_W-1:0]         tc_output,
    input  logic                     tc_done,
    output logic                     busy
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    sched_state_t       state;
    sched_state_t       state_next;
    logic [IDX_W-1:0]   last_grant;
    logic [NUM_REQ-1:0] grant_oh;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_oh_q;
    logic [IDX_W-1:0]   grant_idx_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic [MAT_W-1:0]   a_sel;
    logic [MAT_W-1:0]   b_sel;
    logic               start_job;
    logic               take_done;
    logic               take_timeout;
    logic               resp_accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arbiter (
        .request    (req_valid),
        .last_grant (last_grant),
        .grant      (grant_oh)
    );

    // Winner index and its operand slices.
    always_comb begin
        grant_idx = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                grant_idx = IDX_W'(i);
                a_sel     = req_a[i*MAT_W +: MAT_W];
                b_sel     = req_b[i*MAT_W +: MAT_W];
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        req_ready       = '0;
        resp_valid      = '0;
        tc_write_enable = 1'b0;
        busy            = 1'b1;
        start_job       = 1'b0;
        take_done       = 1'b0;
        take_timeout    = 1'b0;
        resp_accept     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                // Gated so the handshake stays quiet while reset is held.
                req_ready = reset_n ? grant_oh : '0;
                if (|req_valid) begin
                    start_job  = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                tc_write_enable = 1'b1;
                state_next      = WAIT;
            end
            WAIT: begin
                // wait_cnt is zero in the first WAIT cycle, where tc_done
                // still reflects the previous job and must not be trusted.
                if ((wait_cnt != '0) && tc_done) begin
                    take_done  = 1'b1;
                    state_next = RESP;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    take_timeout = 1'b1;
                    state_next   = RESP;
                end
            end
            RESP: begin
                resp_valid = grant_oh_q;
                if (|(resp_ready & grant_oh_q)) begin
                    resp_accept = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            last_grant  <= IDX_W'(NUM_REQ - 1);
            grant_oh_q  <= '0;
            grant_idx_q <= '0;
            wait_cnt    <= '0;
            tc_input1   <= '0;
            tc_input2   <= '0;
            resp_data   <= '0;
            resp_error  <= 1'b0;
        end else begin
            if (start_job) begin
                grant_oh_q  <= grant_oh;
                grant_idx_q <= grant_idx;
                tc_input1   <= a_sel;
                tc_input2   <= b_sel;
            end
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (take_done) begin
                resp_data  <= tc_output;
                resp_error <= 1'b0;
            end else if (take_timeout) begin
                resp_data  <= ABORT_DATA;
                resp_error <= 1'b1;
            end
            if (resp_accept) begin
                last_grant <= grant_idx_q;
            end
        end
    end

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// tb/tb_tensor_core_scheduler.sv - self-checking bench for tensor_core_scheduler
module tb_tensor_core_scheduler;
    import tensor_core_pkg::*;

    localparam int N   = 2;
    localparam int TMO = 24;
    localparam logic [127:0] IDENT = 128'h01000000_00010000_00000100_00000001;
    localparam logic [127:0] ALL1  = {16{8'h01}};
    localparam logic [127:0] ALL2  = {16{8'h02}};
    localparam logic [127:0] ALL4  = {16{8'h04}};
    localparam logic [127:0] RAMP  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] STALE = {16{8'hEE}};

    logic             clock_in = 1'b0;
    logic             reset_n  = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*128-1:0] req_a = '0;
    logic [N*128-1:0] req_b = '0;
    logic [N-1:0]     resp_valid;
    logic [N-1:0]     resp_ready = '0;
    logic [127:0]     resp_data;
    logic             resp_error;
    logic             tc_write_enable;
    logic [127:0]     tc_input1;
    logic [127:0]     tc_input2;
    logic [127:0]     tc_output = '0;
    logic             tc_done = 1'b0;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // core model knobs
    int core_delay = 17;
    bit stale_mode = 0;
    bit never_done = 0;

    // bench model of the scheduler
    bit           m_job = 0;
    bit           m_res = 0;
    int           m_owner, m_acc, m_res_cyc;
    int           m_last = N - 1;
    logic [127:0] m_a, m_b, m_data;
    logic         m_err;

    // observations of the DUT for directed checks
    int           grant_cnt = 0;
    int           grant_log[$];
    int           last_acc_cyc = 0;
    int           resp_cnt = 0;
    int           rise_cyc = 0;
    logic [127:0] rise_data = '0;
    logic         rise_err = 1'b0;
    int           we_cnt = 0;
    bit           prev_rv = 0;

    tensor_core_scheduler #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
        .clock_in        (clock_in),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_a           (req_a),
        .req_b           (req_b),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_error      (resp_error),
        .tc_write_enable (tc_write_enable),
        .tc_input1       (tc_input1),
        .tc_input2       (tc_input2),
        .tc_output       (tc_output),
        .tc_done         (tc_done),
        .busy            (busy)
    );

    always #5 clock_in = ~clock_in;
    always @(posedge clock_in) cyc++;

    // 4x4 signed int8 product, each element wrapped to 8 bits.
    function automatic logic [127:0] matmul(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) begin
                    s += int'($signed(a[(i*4+k)*ELEM_W +: ELEM_W])) *
                         int'($signed(b[(k*4+j)*ELEM_W +: ELEM_W]));
                end
                r[(i*4+j)*ELEM_W +: ELEM_W] = s[7:0];
            end
        end
        return r;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int off = 1; off <= N; off++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && i == (last + off) % N) return i;
            end
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset_n   = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_grants(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (grant_cnt < n && t < budget) begin
            tick();
            t++;
        end
        checks++;
        if (grant_cnt < n) begin
            errors++;
            $display("FAIL %s: timeout, grants %0d expected %0d", name, grant_cnt, n);
        end
    endtask

    task automatic wait_resps(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (resp_cnt < n && t < budget) begin
            tick();
            t++;
        end
        checks++;
        if (resp_cnt < n) begin
            errors++;
            $display("FAIL %s: timeout, responses %0d expected %0d", name, resp_cnt, n);
        end
    endtask

    // Tensor core stand-in: result appears core_delay cycles after the start
    // pulse and done stays high until the next job is well under way.
    initial begin : core_model
        bit           job_active;
        int           we_at, kk;
        logic [127:0] core_res;
        job_active = 0;
        we_at      = 0;
        core_res   = '0;
        forever begin
            @(negedge clock_in);
            if (!reset_n) begin
                job_active = 0;
            end else if (tc_write_enable) begin
                job_active = 1;
                we_at      = cyc;
                core_res   = matmul(tc_input1, tc_input2);
            end
            @(posedge clock_in);
            #1;
            if (!reset_n || !job_active || never_done) begin
                tc_done   = 1'b0;
                tc_output = '0;
            end else begin
                kk = cyc - we_at;
                if (stale_mode && kk <= 1) begin
                    tc_done   = 1'b1;
                    tc_output = STALE;
                end else if (kk >= core_delay) begin
                    tc_done   = 1'b1;
                    tc_output = core_res;
                end else begin
                    tc_done   = 1'b0;
                    tc_output = '0;
                end
            end
        end
    end

    // Per-cycle comparison against the job-level model.
    initial begin : compare_proc
        int g, k, gi;
        logic [N-1:0] e_rr, e_rv;
        forever begin
            @(negedge clock_in);
            if (!reset_n) begin
                check("rst_req_ready", 128'(req_ready), 128'(0));
                check("rst_resp_valid", 128'(resp_valid), 128'(0));
                check("rst_busy", 128'(busy), 128'(0));
                check("rst_tc_we", 128'(tc_write_enable), 128'(0));
                check("rst_tc_input1", tc_input1, 128'(0));
                check("rst_tc_input2", tc_input2, 128'(0));
                check("rst_resp_data", resp_data, 128'(0));
                check("rst_resp_error", 128'(resp_error), 128'(0));
                m_job   = 0;
                m_res   = 0;
                m_last  = N - 1;
                prev_rv = 0;
            end else begin
                e_rr = '0;
                e_rv = '0;
                k    = 0;
                g    = -1;
                if (!m_job) begin
                    g = rr_pick(req_valid, m_last);
                    if (g >= 0) e_rr = N'(1) << g;
                end else begin
                    k = cyc - m_acc;
                    if (m_res && cyc > m_res_cyc) e_rv = N'(1) << m_owner;
                end
                check("req_ready", 128'(req_ready), 128'(e_rr));
                check("tc_write_enable", 128'(tc_write_enable), 128'(m_job && k == 1));
                check("busy", 128'(busy), 128'(m_job));
                check("resp_valid", 128'(resp_valid), 128'(e_rv));
                if (m_job && k >= 1) begin
                    check("tc_input1", tc_input1, m_a);
                    check("tc_input2", tc_input2, m_b);
                end
                if (e_rv != '0) begin
                    check("resp_data", resp_data, m_data);
                    check("resp_error", 128'(resp_error), 128'(m_err));
                end

                if (req_ready != '0) begin
                    gi = -1;
                    for (int i = 0; i < N; i++) if (req_ready == (N'(1) << i)) gi = i;
                    grant_log.push_back(gi);
                    grant_cnt++;
                    last_acc_cyc = cyc;
                end
                if (tc_write_enable) we_cnt++;
                if ((resp_valid != '0) && !prev_rv) begin
                    resp_cnt++;
                    rise_cyc  = cyc;
                    rise_data = resp_data;
                    rise_err  = resp_error;
                end
                prev_rv = (resp_valid != '0);

                if (!m_job) begin
                    if (g >= 0) begin
                        m_job   = 1;
                        m_res   = 0;
                        m_owner = g;
                        m_a     = 128'(req_a >> (g * 128));
                        m_b     = 128'(req_b >> (g * 128));
                        m_acc   = cyc;
                    end
                end else if (!m_res) begin
                    if (k >= 3 && tc_done) begin
                        m_res = 1; m_data = matmul(m_a, m_b); m_err = 1'b0; m_res_cyc = cyc;
                    end else if (k - 1 == TMO) begin
                        m_res = 1; m_data = '0; m_err = 1'b1; m_res_cyc = cyc;
                    end
                end else if (cyc > m_res_cyc && (resp_ready & (N'(1) << m_owner)) != '0) begin
                    m_job  = 0;
                    m_last = m_owner;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int base, g0, r0, w0;

        // Pin the model's arithmetic.
        check("model_ident_x_all2", matmul(IDENT, ALL2), ALL2);
        check("model_all1_x_all1", matmul(ALL1, ALL1), ALL4);

        // Single job, nominal 17-cycle core.
        do_reset();
        core_delay = 17;
        req_a = {ALL1, IDENT};
        req_b = {ALL1, ALL2};
        resp_ready = 2'b11;
        base = grant_log.size(); w0 = we_cnt; r0 = resp_cnt;
        req_valid = 2'b01;
        wait_grants(grant_cnt + 1, 20, "single_grant");
        req_valid = 2'b00;
        wait_resps(r0 + 1, 60, "single_resp");
        check("single_port", 128'(grant_log[base]), 128'(0));
        check("single_latency", 128'(rise_cyc - last_acc_cyc), 128'(19));
        check("single_data", rise_data, ALL2);
        check("single_error", 128'(rise_err), 128'(0));
        check("single_we_pulses", 128'(we_cnt - w0), 128'(1));
        repeat (3) tick();

        // Contention: both ports requesting for three jobs.
        do_reset();
        req_a = {ALL1, IDENT};
        req_b = {ALL1, RAMP};
        base = grant_log.size(); g0 = grant_cnt; r0 = resp_cnt;
        req_valid = 2'b11;
        wait_grants(g0 + 3, 150, "contention_grants");
        req_valid = 2'b00;
        wait_resps(r0 + 3, 60, "contention_resps");
        check("contention_g0", 128'(grant_log[base]), 128'(0));
        check("contention_g1", 128'(grant_log[base + 1]), 128'(1));
        check("contention_g2", 128'(grant_log[base + 2]), 128'(0));
        check("contention_data_last", rise_data, RAMP);
        repeat (3) tick();

        // Stale done held through ISSUE and the first WAIT cycle.
        stale_mode = 1; core_delay = 2;
        r0 = resp_cnt; g0 = grant_cnt;
        req_valid = 2'b10;
        wait_grants(g0 + 1, 20, "stale_grant");
        req_valid = 2'b00;
        wait_resps(r0 + 1, 20, "stale_resp");
        check("stale_latency", 128'(rise_cyc - last_acc_cyc), 128'(4));
        check("stale_data", rise_data, ALL4);
        stale_mode = 0;
        repeat (3) tick();

        // Timeout: the core never finishes.
        never_done = 1; core_delay = 17;
        r0 = resp_cnt; g0 = grant_cnt;
        req_valid = 2'b01;
        wait_grants(g0 + 1, 20, "timeout_grant");
        req_valid = 2'b00;
        wait_resps(r0 + 1, 60, "timeout_resp");
        check("timeout_latency", 128'(rise_cyc - last_acc_cyc), 128'(26));
        check("timeout_error", 128'(rise_err), 128'(1));
        check("timeout_data", rise_data, 128'(0));
        never_done = 0;
        repeat (3) tick();

        // Backpressure; port 1 waits and then gives up before being served.
        core_delay = 5;
        req_a = {ALL1, ALL1};
        req_b = {ALL1, IDENT};
        resp_ready = 2'b10;
        r0 = resp_cnt; g0 = grant_cnt;
        req_valid = 2'b01;
        wait_grants(g0 + 1, 20, "bp_grant");
        req_valid = 2'b11;
        wait_resps(r0 + 1, 30, "bp_resp");
        check("bp_data", rise_data, ALL1);
        for (int i = 0; i < 10; i++) begin
            check("bp_resp_valid", 128'(resp_valid), 128'(2'b01));
            check("bp_resp_data", resp_data, ALL1);
            check("bp_no_grant", 128'(grant_cnt), 128'(g0 + 1));
            tick();
        end
        req_valid = 2'b00;
        resp_ready = 2'b01;
        repeat (6) tick();
        check("bp_dropped_not_granted", 128'(grant_cnt), 128'(g0 + 1));
        check("bp_idle", 128'(busy), 128'(0));

        // Reset in the middle of WAIT.
        core_delay = 17;
        resp_ready = 2'b11;
        g0 = grant_cnt;
        req_valid = 2'b10;
        wait_grants(g0 + 1, 20, "rstjob_grant");
        req_valid = 2'b00;
        repeat (5) tick();
        check("rstjob_busy_before", 128'(busy), 128'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("rstjob_busy", 128'(busy), 128'(0));
        check("rstjob_tc_input1", tc_input1, 128'(0));
        check("rstjob_tc_input2", tc_input2, 128'(0));
        check("rstjob_resp_data", resp_data, 128'(0));
        check("rstjob_resp_valid", 128'(resp_valid), 128'(0));
        check("rstjob_req_ready", 128'(req_ready), 128'(0));
        tick();
        tick();
        reset_n = 1'b1;
        base = grant_log.size(); g0 = grant_cnt; r0 = resp_cnt;
        req_valid = 2'b11;
        wait_grants(g0 + 1, 20, "after_rst_grant");
        req_valid = 2'b00;
        check("after_rst_port", 128'(grant_log[base]), 128'(0));
        wait_resps(r0 + 1, 60, "after_rst_resp");
        repeat (5) tick();
        check("after_rst_one_resp", 128'(resp_cnt - r0), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
